// File: rtl/display_result_writer_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// | Module   : disp_pkg                                                     |
// | Purpose  : Shared constants, FSM state type, BCD vector type and the    |
// |            double-dabble nibble adjust for display_result_writer.       |
// | Revision : 1.0 - initial release                                        |
// ---------------------------------------------------------------------------
package disp_pkg;

   localparam int         NDIG_DEFAULT = 8;
   localparam int         W_DEFAULT    = 27;
   localparam logic [3:0] NOWRITE      = 4'hF;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CONV  = 2'd1,
      WRITE = 2'd2,
      DONE  = 2'd3
   } state_t;

   // One nibble per display digit, digit 0 in the least significant nibble.
   typedef logic [NDIG_DEFAULT-1:0][3:0] bcd_t;

   // Pre-shift correction: a nibble of 5 or more would become >= 10 once
   // doubled, so bias it by 3 so the carry lands in the next nibble.
   function automatic logic [3:0] dd_adjust(input logic [3:0] n);
      return (n >= 4'd5) ? (n + 4'd3) : n;
   endfunction

endpackage
`default_nettype wire

// File: rtl/display_result_writer_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// | Module   : display_result_writer_if                                     |
// | Purpose  : Request side (start/value) and display-bank write side       |
// |            (dig/pos) plus status of the result writer.                  |
// | Revision : 1.0 - initial release                                        |
// ---------------------------------------------------------------------------
interface display_result_writer_if #(
   parameter int W = disp_pkg::W_DEFAULT
);
   logic         start;
   logic [W-1:0] value;
   logic [3:0]   dig;
   logic [3:0]   pos;
   logic         busy;
   logic         done;
   logic         ovf;

   // Requester / bank-side view.
   modport master (
      output start, value,
      input  dig, pos, busy, done, ovf
   );

   // Result writer view.
   modport slave (
      input  start, value,
      output dig, pos, busy, done, ovf
   );
endinterface
`default_nettype wire

// File: rtl/display_result_writer_bin2bcd_seq.sv
`default_nettype none
// ---------------------------------------------------------------------------
// | Module   : bin2bcd_seq                                                  |
// | Purpose  : Iterative double-dabble converter. load clears the BCD       |
// |            register and captures the binary value; each step adjusts    |
// |            and shifts in one binary bit, MSB first.                     |
// | Revision : 1.0 - initial release                                        |
// ---------------------------------------------------------------------------
module bin2bcd_seq
   import disp_pkg::*;
#(
   parameter int NDIG = NDIG_DEFAULT,
   parameter int W    = W_DEFAULT
) (
   input  logic                 clock_i,
   input  logic                 reset_i,
   input  logic                 load_i,
   input  logic                 step_i,
   input  logic [W-1:0]         value_i,
   output logic [NDIG-1:0][3:0] bcd_o
);

   logic [W-1:0]      bin_q;
   logic [W-1:0]      bin_d;
   logic [NDIG*4-1:0] bcd_q;
   logic [NDIG*4-1:0] bcd_d;
   logic [NDIG*4-1:0] adj_w;

   // Next-state of one double-dabble iteration (or load / hold).
   always_comb begin
      adj_w = bcd_q;
      for (int i = 0; i < NDIG; i++) begin
         adj_w[i*4 +: 4] = dd_adjust(bcd_q[i*4 +: 4]);
      end
      bin_d = bin_q;
      bcd_d = bcd_q;
      if (load_i) begin
         bin_d = value_i;
         bcd_d = '0;
      end else if (step_i) begin
         // Value is clamped upstream, so nothing meaningful leaves the top.
         bcd_d = (adj_w << 1) | {{(NDIG*4-1){1'b0}}, bin_q[W-1]};
         bin_d = bin_q << 1;
      end
   end

   // Conversion registers.
   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         bin_q <= '0;
         bcd_q <= '0;
      end else begin
         bin_q <= bin_d;
         bcd_q <= bcd_d;
      end
   end

   assign bcd_o = bcd_q;

endmodule
`default_nettype wire

// File: rtl/display_result_writer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// | Module   : display_result_writer                                        |
// | Purpose  : Converts a binary result to BCD and writes it into the       |
// |            display bank one (dig, pos) pair per clock, LSD first.       |
// | Options  : DISPLAY_RESULT_WRITER_LZ_SKIP_EN - stop writing after the    |
// |            highest non-zero digit (digit 0 is always written).          |
// | Revision : 1.0 - initial release                                        |
// ---------------------------------------------------------------------------
module display_result_writer
   import disp_pkg::*;
#(
   parameter int NDIG = NDIG_DEFAULT,
   parameter int W    = W_DEFAULT
) (
   input  logic                    clock_i,
   input  logic                    reset_i,
   display_result_writer_if.slave  bus
);

   localparam int               CW        = $clog2(W + 1);
   localparam logic [CW-1:0]    CONV_LAST = CW'(W - 1);
   localparam logic [W-1:0]     MAX_VALUE = W'(10**NDIG - 1);

   state_t                state_q;
   logic [CW-1:0]         conv_cnt_q;
   logic [3:0]            wr_cnt_q;
   logic [3:0]            dig_q;
   logic [3:0]            pos_q;
   logic                  busy_q;
   logic                  done_q;
   logic                  ovf_q;

   logic                  accept_w;
   logic                  ovf_w;
   logic [W-1:0]          load_value_w;
   logic                  step_w;
   logic [NDIG-1:0][3:0]  bcd_w;
   logic [3:0]            wr_dig_w;
   logic [3:0]            last_w;

   // busy_q also covers the DONE pulse cycle, so start is only taken when
   // the outside world sees busy low.
   assign accept_w     = (state_q == IDLE) && !busy_q && bus.start;
   assign ovf_w        = (bus.value > MAX_VALUE);
   assign load_value_w = ovf_w ? MAX_VALUE : bus.value;
   assign step_w       = (state_q == CONV);

   bin2bcd_seq #(
      .NDIG (NDIG),
      .W    (W)
   ) u_bin2bcd (
      .clock_i (clock_i),
      .reset_i (reset_i),
      .load_i  (accept_w),
      .step_i  (step_w),
      .value_i (load_value_w),
      .bcd_o   (bcd_w)
   );

   // Select the BCD nibble addressed by the write counter.
   always_comb begin
      wr_dig_w = 4'd0;
      for (int i = 0; i < NDIG; i++) begin
         if (wr_cnt_q == 4'(i)) wr_dig_w = bcd_w[i];
      end
   end

`ifdef DISPLAY_RESULT_WRITER_LZ_SKIP_EN
   // Last position to write is the highest non-zero nibble (0 for value 0).
   always_comb begin
      last_w = 4'd0;
      for (int i = 0; i < NDIG; i++) begin
         if (bcd_w[i] != 4'd0) last_w = 4'(i);
      end
   end
`else
   assign last_w = 4'(NDIG - 1);
`endif

   // Sequencer FSM with registered bank-write and status outputs.
   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         state_q    <= IDLE;
         conv_cnt_q <= '0;
         wr_cnt_q   <= 4'd0;
         dig_q      <= NOWRITE;
         pos_q      <= NOWRITE;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         ovf_q      <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               dig_q  <= NOWRITE;
               pos_q  <= NOWRITE;
               done_q <= 1'b0;
               busy_q <= accept_w;
               if (accept_w) begin
                  ovf_q      <= ovf_w;
                  conv_cnt_q <= '0;
                  state_q    <= CONV;
               end
            end
            CONV: begin
               if (conv_cnt_q == CONV_LAST) begin
                  wr_cnt_q <= 4'd0;
                  state_q  <= WRITE;
               end else begin
                  conv_cnt_q <= conv_cnt_q + 1'b1;
               end
            end
            WRITE: begin
               pos_q <= wr_cnt_q;
               dig_q <= wr_dig_w;
               if (wr_cnt_q == last_w) begin
                  state_q <= DONE;
               end else begin
                  wr_cnt_q <= wr_cnt_q + 4'd1;
               end
            end
            DONE: begin
               pos_q   <= NOWRITE;
               dig_q   <= NOWRITE;
               done_q  <= 1'b1;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.dig  = dig_q;
   assign bus.pos  = pos_q;
   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.ovf  = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_display_result_writer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// | Module   : tb_display_result_writer                                     |
// | Purpose  : Self-checking bench: cycle-level reference model of the      |
// |            write sequence plus literal write-log expectations.          |
// | Revision : 1.0 - initial release                                        |
// ---------------------------------------------------------------------------
module tb_display_result_writer;

   localparam int NDIG = 8;
   localparam int W    = 27;

   logic clock = 1'b0;
   logic reset;

   display_result_writer_if #(.W(W)) bus ();

   display_result_writer #(
      .NDIG (NDIG),
      .W    (W)
   ) dut (
      .clock_i (clock),
      .reset_i (reset),
      .bus     (bus)
   );

   always #5 clock = ~clock;

   int checks   = 0;
   int failures = 0;

   // Reference model state.
   int   edge_n    = 0;
   int   run_start = -1;
   int   acc_edge  = 0;
   int   m_len     = NDIG;
   int   m_dig[NDIG];
   logic m_ovf     = 1'b0;

   typedef struct {
      int rel;
      int pos;
      int dig;
   } wr_t;

   wr_t         wlog[$];
   wr_t         e_rec;
   int          done_cnt = 0;
   int          done_rel = -1;
   logic [10:0] exp_now;
   logic [10:0] act_now;
   logic [10:0] busy_chk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: actual=%0h required=%0h at t=%0t", name, act, req, $time);
      end
   endtask

   // Capture a new request: decimal digits of the (clamped) value.
   function automatic void model_accept(input longint unsigned v);
      longint unsigned vv;
      vv    = v;
      m_ovf = (v > 64'd99999999);
      if (m_ovf) vv = 64'd99999999;
      m_len = NDIG;
`ifdef DISPLAY_RESULT_WRITER_LZ_SKIP_EN
      m_len = 1;
`endif
      for (int k = 0; k < NDIG; k++) begin
         m_dig[k] = int'(vv % 64'd10);
         vv       = vv / 64'd10;
`ifdef DISPLAY_RESULT_WRITER_LZ_SKIP_EN
         if (m_dig[k] != 0) m_len = k + 1;
`endif
      end
   endfunction

   // Expected {dig,pos,busy,done,ovf} in the cycle following edge n.
   function automatic logic [10:0] model_out(input int n);
      int         rel;
      logic [3:0] d;
      logic [3:0] p;
      logic       b;
      logic       dn;
      d  = 4'hF;
      p  = 4'hF;
      b  = 1'b0;
      dn = 1'b0;
      if (run_start >= 0) begin
         rel = n - run_start;
         if (rel >= 0 && rel <= W + m_len + 1) b = 1'b1;
         if (rel >= W + 1 && rel <= W + m_len) begin
            p = 4'(rel - W - 1);
            d = 4'(m_dig[rel - W - 1]);
         end
         if (rel == W + m_len + 1) dn = 1'b1;
      end
      return {d, p, b, dn, m_ovf};
   endfunction

   // Model clocking: a start is taken whenever the model was not busy.
   always @(posedge clock or posedge reset) begin
      if (reset) begin
         run_start = -1;
         m_ovf     = 1'b0;
      end else begin
         busy_chk = model_out(edge_n);
         edge_n   = edge_n + 1;
         if (bus.start === 1'b1 && busy_chk[2] == 1'b0) begin
            model_accept(64'(bus.value));
            run_start = edge_n;
            acc_edge  = edge_n;
         end
      end
   end

   // Per-cycle comparison against the model, plus the bank-write log.
   always @(negedge clock) begin
      exp_now = model_out(edge_n);
      act_now = {bus.dig, bus.pos, bus.busy, bus.done, bus.ovf};
      check("cycle", 32'(act_now), 32'(exp_now));
      if (bus.pos !== 4'hF) begin
         e_rec.rel = edge_n - acc_edge;
         e_rec.pos = int'(bus.pos);
         e_rec.dig = int'(bus.dig);
         wlog.push_back(e_rec);
      end
      if (bus.done === 1'b1) begin
         done_cnt++;
         done_rel = edge_n - acc_edge;
      end
   end

   task automatic clear_log();
      wlog.delete();
      done_cnt = 0;
      done_rel = -1;
   endtask

   task automatic do_start(input int v);
      @(posedge clock);
      #2;
      bus.start = 1'b1;
      bus.value = W'(v);
      @(posedge clock);
      #2;
      bus.start = 1'b0;
   endtask

   task automatic pulse_stray(input int v);
      bus.start = 1'b1;
      bus.value = W'(v);
      @(posedge clock);
      #2;
      bus.start = 1'b0;
   endtask

   // Literal expectations: write k at cycle 28+k, pos k, dig = nibble k of lit.
   task automatic check_log(input string name, input logic [31:0] lit, input int nw,
                            input int drel, input int ndone);
      logic [31:0] l;
      l = lit;
      check({name, "_nwrites"}, 32'(wlog.size()), 32'(nw));
      for (int i = 0; i < nw && i < wlog.size(); i++) begin
         check({name, "_rel"}, 32'(wlog[i].rel), 32'(28 + i));
         check({name, "_pos"}, 32'(wlog[i].pos), 32'(i));
         check({name, "_dig"}, 32'(wlog[i].dig), 32'(l[4*i +: 4]));
      end
      check({name, "_ndone"}, 32'(done_cnt), 32'(ndone));
      if (ndone > 0) check({name, "_donerel"}, 32'(done_rel), 32'(drel));
   endtask

   initial begin
      reset     = 1'b1;
      bus.start = 1'b0;
      bus.value = '0;
      repeat (3) @(posedge clock);
      #2;
      check("rst_dig",  32'(bus.dig),  32'hF);
      check("rst_pos",  32'(bus.pos),  32'hF);
      check("rst_busy", 32'(bus.busy), 32'h0);
      check("rst_done", 32'(bus.done), 32'h0);
      check("rst_ovf",  32'(bus.ovf),  32'h0);
      reset = 1'b0;

      // Typical value.
      clear_log();
      do_start(12345678);
      repeat (40) @(posedge clock);
      #2;
      check_log("v12345678", 32'h12345678, 8, 36, 1);
      check("v12345678_ovf", 32'(bus.ovf), 32'h0);

      // Zero.
      clear_log();
      do_start(0);
      repeat (40) @(posedge clock);
      #2;
`ifdef DISPLAY_RESULT_WRITER_LZ_SKIP_EN
      check_log("zero", 32'h0, 1, 29, 1);
`else
      check_log("zero", 32'h0, 8, 36, 1);
`endif

      // Overflow clamps to all nines and ovf holds afterwards.
      clear_log();
      do_start(100000000);
      repeat (40) @(posedge clock);
      #2;
      check_log("ovf", 32'h99999999, 8, 36, 1);
      repeat (5) @(posedge clock);
      #2;
      check("ovf_held", 32'(bus.ovf), 32'h1);

      // Next accepted start clears ovf.
      clear_log();
      do_start(42);
      @(negedge clock);
      check("ovf_clear", 32'(bus.ovf), 32'h0);
      repeat (40) @(posedge clock);
      #2;
`ifdef DISPLAY_RESULT_WRITER_LZ_SKIP_EN
      check_log("v42", 32'h42, 2, 30, 1);
`else
      check_log("v42", 32'h00000042, 8, 36, 1);
`endif

      // Stray starts during CONV and WRITE are ignored.
      clear_log();
      do_start(87654321);
      repeat (5) @(posedge clock);
      #2;
      pulse_stray(5);
      repeat (24) @(posedge clock);
      #2;
      pulse_stray(7);
      repeat (12) @(posedge clock);
      #2;
      check_log("repulse", 32'h87654321, 8, 36, 1);

      // Reset in the middle of WRITE aborts at once.
      clear_log();
      do_start(12345678);
      repeat (31) @(posedge clock);
      #2;
      reset = 1'b1;
      #1;
      check("midrst_pos",  32'(bus.pos),  32'hF);
      check("midrst_dig",  32'(bus.dig),  32'hF);
      check("midrst_busy", 32'(bus.busy), 32'h0);
      @(posedge clock);
      #2;
      reset = 1'b0;
      repeat (10) @(posedge clock);
      #2;
      check_log("midrst", 32'h12345678, 3, 0, 0);

      // Normal operation after the abort.
      clear_log();
      do_start(31415926);
      repeat (40) @(posedge clock);
      #2;
      check_log("after_rst", 32'h31415926, 8, 36, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
